branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It serves the fetch stage and is updated from branch resolution. Each cycle it looks up the fetch PC combinationally and returns a taken/not-taken prediction plus the next-PC guess. It learns from resolved conditional branches, JAL and JALR, and keeps wrap-around performance counters for total resolved branches and mispredictions.

## Interface
- ENTRIES, 16: BTB depth; power of two, ≥2; INDEX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, 1..4.
- ALLOC_NOT_TAKEN, 0: 1 = a conditional branch that misses and resolves not-taken also allocates an entry.
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  reset; asynchronous, active-low.
- fetch_pc  in  32  PC being fetched this cycle.
- predict_taken  out  1  fetch_pc predicted as a taken control transfer.
- predict_pc  out  32  predicted next PC.
- upd_valid  in  1  a resolved control-transfer instruction is presented this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_is_cond  in  1  resolved instruction is a conditional branch.
- upd_is_jal  in  1  resolved instruction is JAL.
- upd_is_jalr  in  1  resolved instruction is JALR.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target address.
- upd_mispredict  in  1  resolution disagreed with the prediction carried down the pipe.
- branch_count  out  32  number of accepted updates.
- mispredict_count  out  32  number of accepted updates with upd_mispredict set.

## Operation
- Entry fields: valid, tag = pc[31:INDEX_W+2], target[31:0], uncond (1 bit), ctr[CTR_W-1:0]. Index = pc[INDEX_W+1:2].
- Lookup is purely combinational. hit = valid && tag match. predict_taken = hit && (uncond || ctr[CTR_W-1]). predict_pc = predict_taken ? target : fetch_pc+4, using 32-bit wrap.
- An update is accepted when upd_valid=1 and exactly one of upd_is_cond / upd_is_jal / upd_is_jalr is 1. Any other combination is ignored entirely, including the counters.
- Conditional branch, hit:
  - ctr increments if upd_taken, saturating at 2^CTR_W-1; otherwise decrements, saturating at 0.
  - target is overwritten with upd_target only if upd_taken.
  - uncond is cleared.
- Conditional branch, miss:
  - If upd_taken: allocate with valid=1, tag, target, uncond=0, ctr = 2^(CTR_W-1) (weakly taken). This overwrites any aliasing entry.
  - If not taken: allocate only when ALLOC_NOT_TAKEN=1, with ctr = 2^(CTR_W-1)-1 (weakly not-taken). Otherwise no change.
- JAL/JALR, hit or miss: write valid=1, tag, target=upd_target, uncond=1, ctr = all ones. upd_taken is ignored.
- Performance counters:
  - branch_count increments by 1 per accepted update.
  - mispredict_count increments by 1 per accepted update with upd_mispredict=1.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- Lookup latency is 0 cycles: outputs follow fetch_pc in the same cycle.
- Update latency is 1 cycle: table state changes at the edge ending the update cycle.
- A lookup and an update to the same index in the same cycle: the lookup sees the old contents (no bypass). The new contents are visible from the next cycle.
- There is no stall input. Fetch holds fetch_pc during a stall, so the prediction stays stable unless an update retrains that entry.
- Reset, asynchronous assert, any time including mid-update:
  - every valid=0; every ctr = 2^(CTR_W-1)-1; target, tag and uncond = 0.
  - branch_count = mispredict_count = 0.
  - Outputs are therefore predict_taken=0 and predict_pc = fetch_pc+4.
  - An update coincident with reset is lost.
- Deassertion takes effect at the first rising clk after arst_n goes high.

## Test plan
- Reset with fetch_pc=0x100, after no updates → predict_taken=0, predict_pc=0x104, both counters 0.
- Update cond taken at pc=0x100, target 0x80 (ENTRIES=16, CTR_W=2). Next cycle with fetch_pc=0x100 → predict_taken=1, predict_pc=0x80. Then two not-taken updates → ctr reaches 00, predict_pc=0x104. Then three taken updates → ctr saturates at 11.
- Aliasing: pc 0x100 trained taken, then pc 0x500 updated as JAL target 0x40 (same index). Lookup 0x100 → miss, predict_pc=0x104. Lookup 0x500 → taken, predict_pc=0x40.
- Same-cycle lookup and update of 0x200 (first-time taken) → predict_taken=0 that cycle, 1 the next cycle.
- Counters: mispredict_count preloaded via 0xFFFFFFFF+1 accepted mispredict updates (or forced) wraps to 0. An update with upd_is_cond=upd_is_jal=1 leaves table and counters unchanged.
- ALLOC_NOT_TAKEN=1: not-taken miss at 0x300 → entry valid, predict_taken=0. One taken update → predict_taken=1 (ctr 10).

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolution-side update bundle for the branch target buffer.
// master = pipeline (drives fetch PC and resolutions), slave = predictor.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_pc;

  // Update handshake: upd_valid qualifies every upd_* field for exactly one
  // cycle; there is no ready, the predictor always accepts or ignores.
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_is_jal;
  logic        upd_is_jalr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_is_cond, upd_is_jal, upd_is_jalr,
           upd_taken, upd_target, upd_mispredict,
    input  predict_taken, predict_pc, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_is_cond, upd_is_jal, upd_is_jalr,
           upd_taken, upd_target, upd_mispredict,
    output predict_taken, predict_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and
// wrap-around performance counters; combinational lookup, registered update.
module branch_predictor #(
  parameter int ENTRIES         = 16,
  parameter int CTR_W           = 2,
  parameter int ALLOC_NOT_TAKEN = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  branch_predictor_if.slave bp
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = 32 - INDEX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic             r_uncond [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];

  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Lookup path
  logic [INDEX_W-1:0] w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic               w_fhit;
  logic               w_ftaken;

  assign w_fidx   = bp.fetch_pc[INDEX_W+1:2];
  assign w_ftag   = bp.fetch_pc[31:INDEX_W+2];
  assign w_fhit   = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_ftaken = w_fhit && (r_uncond[w_fidx] || r_ctr[w_fidx][CTR_W-1]);

  assign bp.predict_taken    = w_ftaken;
  assign bp.predict_pc       = w_ftaken ? r_target[w_fidx] : (bp.fetch_pc + 32'd4);
  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;

  // Update path: an update counts only when exactly one instruction kind is flagged
  logic [INDEX_W-1:0] w_uidx;
  logic [TAG_W-1:0]   w_utag;
  logic               w_uhit;
  logic               w_one_kind;
  logic               w_accept;
  logic               w_is_jump;

  assign w_uidx     = bp.upd_pc[INDEX_W+1:2];
  assign w_utag     = bp.upd_pc[31:INDEX_W+2];
  assign w_uhit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_one_kind = ( bp.upd_is_cond && !bp.upd_is_jal && !bp.upd_is_jalr) ||
                      (!bp.upd_is_cond &&  bp.upd_is_jal && !bp.upd_is_jalr) ||
                      (!bp.upd_is_cond && !bp.upd_is_jal &&  bp.upd_is_jalr);
  assign w_accept   = bp.upd_valid && w_one_kind;
  assign w_is_jump  = bp.upd_is_jal || bp.upd_is_jalr;

  logic             w_we;
  logic [31:0]      w_n_target;
  logic             w_n_uncond;
  logic [CTR_W-1:0] w_n_ctr;

  always_comb begin
    w_we       = 1'b0;
    w_n_target = r_target[w_uidx];
    w_n_uncond = r_uncond[w_uidx];
    w_n_ctr    = r_ctr[w_uidx];
    if (w_accept) begin
      if (w_is_jump) begin
        w_we       = 1'b1;
        w_n_target = bp.upd_target;
        w_n_uncond = 1'b1;
        w_n_ctr    = CTR_MAX;
      end else if (w_uhit) begin
        w_we       = 1'b1;
        w_n_uncond = 1'b0;
        if (bp.upd_taken) begin
          w_n_target = bp.upd_target;
          if (r_ctr[w_uidx] != CTR_MAX) w_n_ctr = r_ctr[w_uidx] + CTR_W'(1);
        end else begin
          if (r_ctr[w_uidx] != '0) w_n_ctr = r_ctr[w_uidx] - CTR_W'(1);
        end
      end else if (bp.upd_taken) begin
        w_we       = 1'b1;
        w_n_target = bp.upd_target;
        w_n_uncond = 1'b0;
        w_n_ctr    = CTR_WT;
      end else if (ALLOC_NOT_TAKEN != 0) begin
        w_we       = 1'b1;
        w_n_target = bp.upd_target;
        w_n_uncond = 1'b0;
        w_n_ctr    = CTR_WNT;
      end
    end
  end

  // Tag and index bits fully cover the PC except the word-offset bits
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_uncond[i] <= 1'b0;
        r_ctr[i]    <= CTR_WNT;
      end
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_we) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= w_n_target;
        r_uncond[w_uidx] <= w_n_uncond;
        r_ctr[w_uidx]    <= w_n_ctr;
      end
      if (w_accept) begin
        r_branch_count <= r_branch_count + 32'd1;
        if (bp.upd_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table of lookup/update vectors on a
// default instance, plus hand sequences for wrap, reset and not-taken allocation.
module tb_branch_predictor;

  logic clk;
  logic arst_n;

  branch_predictor_if if0 ();
  branch_predictor_if if1 ();

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .ALLOC_NOT_TAKEN(0)) dut0 (
    .clk    (clk),
    .arst_n (arst_n),
    .bp     (if0.slave)
  );

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .ALLOC_NOT_TAKEN(1)) dut1 (
    .clk    (clk),
    .arst_n (arst_n),
    .bp     (if1.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  typedef struct {
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic [2:0]  kind;   // {cond, jal, jalr}
    logic        t;
    logic [31:0] tgt;
    logic        m;
    logic        exp_t;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                              input logic [2:0] kind, input logic t, input logic [31:0] tgt,
                              input logic m, input logic exp_t, input logic [31:0] exp_pc);
    vec_t v;
    v.fpc = fpc; v.uv = uv; v.upc = upc; v.kind = kind; v.t = t;
    v.tgt = tgt; v.m = m; v.exp_t = exp_t; v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle0();
    if0.upd_valid = 1'b0; if0.upd_pc = '0; if0.upd_is_cond = 1'b0; if0.upd_is_jal = 1'b0;
    if0.upd_is_jalr = 1'b0; if0.upd_taken = 1'b0; if0.upd_target = '0; if0.upd_mispredict = 1'b0;
  endtask

  task automatic idle1();
    if1.upd_valid = 1'b0; if1.upd_pc = '0; if1.upd_is_cond = 1'b0; if1.upd_is_jal = 1'b0;
    if1.upd_is_jalr = 1'b0; if1.upd_taken = 1'b0; if1.upd_target = '0; if1.upd_mispredict = 1'b0;
  endtask

  task automatic drive0(input vec_t v);
    if0.fetch_pc       = v.fpc;
    if0.upd_valid      = v.uv;
    if0.upd_pc         = v.upc;
    if0.upd_is_cond    = v.kind[2];
    if0.upd_is_jal     = v.kind[1];
    if0.upd_is_jalr    = v.kind[0];
    if0.upd_taken      = v.t;
    if0.upd_target     = v.tgt;
    if0.upd_mispredict = v.m;
  endtask

  // One conditional update on dut1, then an idle cycle before the caller samples
  task automatic upd1(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    if1.fetch_pc    = pc;
    if1.upd_valid   = 1'b1;
    if1.upd_pc      = pc;
    if1.upd_is_cond = 1'b1;
    if1.upd_taken   = taken;
    if1.upd_target  = tgt;
    @(negedge clk);
    idle1();
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] e_pc;

    // Table: lookup expectations reflect state before that row's update lands
    vt.push_back(mk(32'h100, 0, 32'h000, 3'b000, 0, 32'h000, 0, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 1, 32'h080, 1, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 0, 32'h000, 1, 1, 32'h080));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 0, 32'h000, 0, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 0, 32'h000, 0, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 1, 32'h080, 0, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 1, 32'h080, 0, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 1, 32'h080, 1, 1, 32'h080));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 1, 32'h080, 0, 1, 32'h080));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 0, 32'h000, 0, 1, 32'h080));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 0, 32'h999, 0, 1, 32'h080));
    vt.push_back(mk(32'h100, 1, 32'h100, 3'b100, 1, 32'h090, 1, 0, 32'h104));
    vt.push_back(mk(32'h100, 1, 32'h500, 3'b010, 0, 32'h040, 1, 1, 32'h090));
    vt.push_back(mk(32'h100, 0, 32'h000, 3'b000, 0, 32'h000, 0, 0, 32'h104));
    vt.push_back(mk(32'h500, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h040));
    vt.push_back(mk(32'h500, 1, 32'h500, 3'b100, 0, 32'h000, 0, 1, 32'h040));
    vt.push_back(mk(32'h500, 1, 32'h500, 3'b100, 0, 32'h000, 0, 1, 32'h040));
    vt.push_back(mk(32'h500, 0, 32'h000, 3'b000, 0, 32'h000, 0, 0, 32'h504));
    vt.push_back(mk(32'h200, 1, 32'h200, 3'b100, 1, 32'h600, 0, 0, 32'h204));
    vt.push_back(mk(32'h200, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h600));
    vt.push_back(mk(32'h304, 1, 32'h304, 3'b100, 0, 32'h000, 1, 0, 32'h308));
    vt.push_back(mk(32'h304, 1, 32'h304, 3'b100, 1, 32'h700, 0, 0, 32'h308));
    vt.push_back(mk(32'h304, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h700));
    vt.push_back(mk(32'h200, 1, 32'h200, 3'b110, 0, 32'h123, 1, 1, 32'h600));
    vt.push_back(mk(32'h200, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h600));
    vt.push_back(mk(32'hFFC, 1, 32'hFFC, 3'b001, 0, 32'h000, 1, 0, 32'h1000));
    vt.push_back(mk(32'hFFC, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h000));
    vt.push_back(mk(32'hFFFF_FFFC, 0, 32'h000, 3'b000, 0, 32'h000, 0, 0, 32'h000));
    vt.push_back(mk(32'h304, 0, 32'h304, 3'b010, 0, 32'h777, 1, 1, 32'h700));
    vt.push_back(mk(32'h304, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h700));
    vt.push_back(mk(32'h200, 1, 32'h200, 3'b111, 1, 32'h000, 1, 1, 32'h600));
    vt.push_back(mk(32'h200, 1, 32'h200, 3'b000, 1, 32'h000, 1, 1, 32'h600));
    vt.push_back(mk(32'h200, 0, 32'h000, 3'b000, 0, 32'h000, 0, 1, 32'h600));
    foreach (vt[i]) exp_q.push_back(vt[i].exp_pc);

    // Reset
    arst_n = 1'b0;
    idle0(); idle1();
    if0.fetch_pc = 32'h100;
    if1.fetch_pc = 32'h100;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_taken",   {31'b0, if0.predict_taken}, 32'd0);
    chk("reset_pc",      if0.predict_pc, 32'h104);
    chk("reset_bcount",  if0.branch_count, 32'd0);
    chk("reset_mcount",  if0.mispredict_count, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    exp_bc = '0;
    exp_mc = '0;

    // Table-driven vectors on dut0
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      @(negedge clk);
      drive0(v);
      #1;
      e_pc = exp_q.pop_front();
      chk($sformatf("row%0d_taken", i), {31'b0, if0.predict_taken}, {31'b0, v.exp_t});
      chk($sformatf("row%0d_pc", i),    if0.predict_pc, e_pc);
      chk($sformatf("row%0d_bcount", i), if0.branch_count, exp_bc);
      chk($sformatf("row%0d_mcount", i), if0.mispredict_count, exp_mc);
      if (v.uv && ($countones(v.kind) == 1)) begin
        exp_bc = exp_bc + 32'd1;
        if (v.m) exp_mc = exp_mc + 32'd1;
      end
    end
    @(negedge clk);
    idle0();
    #1;
    chk("post_table_bcount", if0.branch_count, exp_bc);
    chk("post_table_mcount", if0.mispredict_count, exp_mc);

    // Counter wrap: preload both counters to all ones, then one accepted mispredict
    @(negedge clk);
    force dut0.r_branch_count = 32'hFFFF_FFFF;
    force dut0.r_mispredict_count = 32'hFFFF_FFFF;
    #1;
    release dut0.r_branch_count;
    release dut0.r_mispredict_count;
    @(negedge clk);
    drive0(mk(32'h200, 1, 32'h740, 3'b100, 0, 32'h000, 1, 0, 32'h0));
    @(negedge clk);
    idle0();
    #1;
    chk("wrap_bcount", if0.branch_count, 32'd0);
    chk("wrap_mcount", if0.mispredict_count, 32'd0);
    // Two kinds flagged at once: table and counters untouched
    drive0(mk(32'h200, 1, 32'h200, 3'b110, 0, 32'h321, 1, 0, 32'h0));
    @(negedge clk);
    idle0();
    #1;
    chk("illegal_bcount", if0.branch_count, 32'd0);
    chk("illegal_mcount", if0.mispredict_count, 32'd0);
    chk("illegal_taken",  {31'b0, if0.predict_taken}, 32'd1);
    chk("illegal_pc",     if0.predict_pc, 32'h600);

    // Asynchronous reset in the middle of an update cycle: the update is lost
    @(negedge clk);
    drive0(mk(32'h400, 1, 32'h400, 3'b100, 1, 32'h010, 1, 0, 32'h0));
    #2;
    arst_n = 1'b0;
    #1;
    chk("async_rst_bcount", if0.branch_count, 32'd0);
    chk("async_rst_taken",  {31'b0, if0.predict_taken}, 32'd0);
    chk("async_rst_pc",     if0.predict_pc, 32'h404);
    @(posedge clk);
    @(negedge clk);
    idle0();
    arst_n = 1'b1;
    #1;
    chk("midrst_taken",  {31'b0, if0.predict_taken}, 32'd0);
    chk("midrst_pc",     if0.predict_pc, 32'h404);
    chk("midrst_bcount", if0.branch_count, 32'd0);
    chk("midrst_mcount", if0.mispredict_count, 32'd0);
    if0.fetch_pc = 32'h200;
    #1;
    chk("midrst_cleared_taken", {31'b0, if0.predict_taken}, 32'd0);
    chk("midrst_cleared_pc",    if0.predict_pc, 32'h204);

    // Not-taken allocation on dut1
    upd1(32'h300, 1'b0, 32'h800);
    chk("ant_alloc_taken", {31'b0, if1.predict_taken}, 32'd0);
    chk("ant_alloc_pc",    if1.predict_pc, 32'h304);
    chk("ant_bcount",      if1.branch_count, 32'd1);
    upd1(32'h300, 1'b1, 32'h800);
    chk("ant_train_taken", {31'b0, if1.predict_taken}, 32'd1);
    chk("ant_train_pc",    if1.predict_pc, 32'h800);
    // Allocated weakly not-taken, so NT,NT,T leaves it at 01 (not taken)
    upd1(32'h308, 1'b0, 32'h900);
    upd1(32'h308, 1'b0, 32'h900);
    upd1(32'h308, 1'b1, 32'h900);
    chk("ant_seq_taken", {31'b0, if1.predict_taken}, 32'd0);
    chk("ant_seq_pc",    if1.predict_pc, 32'h30C);
    upd1(32'h308, 1'b1, 32'h900);
    chk("ant_seq2_taken", {31'b0, if1.predict_taken}, 32'd1);
    chk("ant_seq2_pc",    if1.predict_pc, 32'h900);
    chk("ant_final_bcount", if1.branch_count, 32'd6);
    chk("ant_final_mcount", if1.mispredict_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
